mac_acc_pipe: RTL
=================

// Module: mac_acc_pipe
// PURPOSE
//  Parametrised successor to the fixed 8-lane pipelined MAC. Takes pr signed lanes of a*b per beat,
//  forms products, and reduces them in a fully registered adder tree. It then accumulates the
//  per-beat sums over a framed group of beats (first/last tags) and emits one partial sum per group.
//  It sits between the operand fetch and the psum writeback in the datapath. It has no backpressure.
// PARAMETERS
//  bw       8          operand width per lane (two's complement)
//  pr       8          lane count; power of 2, >=2; D = $clog2(pr) tree levels
//  bw_psum  2*bw+8     accumulator/output width; must be >= 2*bw+D
// PORTS
//  clk        in   1           clock, rising edge
//  reset      in   1           synchronous, active-low reset
//  in_valid   in   1           beat valid; a/b/in_first/in_last sampled only when high
//  in_first   in   1           beat opens a group (accumulator restarts from this beat)
//  in_last    in   1           beat closes a group (result emitted)
//  a          in   pr*bw       lane operands, lane i = a[bw*(i+1)-1:bw*i]
//  b          in   pr*bw       lane operands, same packing
//  out        out  bw_psum     group sum, signed; holds until next out_valid
//  out_valid  out  1           one-cycle pulse per completed group
//  ovf        out  1           qualified by out_valid; see CONFIGURATION
// BEHAVIOUR
//  - Reset (reset==0 at a clk edge): all pipeline regs, the valid/first/last shift chain, the
//    accumulator, out, out_valid and ovf go to 0. In-flight beats and any open group are discarded.
//  - Stage P (1 cycle): prod[i] <= sext(a_i)*sext(b_i), 2*bw bits signed.
//  - Stages T1..TD (1 cycle each): each level adds pairs with 1-bit sign extension. The final sum
//    has 2*bw+D bits.
//  - Stage A (1 cycle): the sum is sign-extended to bw_psum. Accumulator update:
//      first ? acc <= sum : acc <= acc + sum.
//  - Latency: a beat with in_last at edge t produces out_valid=1 at edge t+D+2. With defaults that
//    is 5 cycles.
//  - valid/first/last travel in a D+1 deep shift chain alongside the data. The data regs are
//    enabled by their stage's valid bit, so bubbles do not disturb the accumulator.
//  - Gaps (in_valid=0) inside a group are allowed and have no effect.
//  - first&last on the same beat: out = that beat's sum.
//  - A beat that is neither first nor last, with no open group, adds onto the stale acc. The
//    result is undefined; the bench treats it as a protocol error.
//  - A second first before a last restarts the group; the partial sum is dropped with no output.
//  - Back-to-back groups (last, then first on the next beat) must not bleed into each other.
//  - out_valid pulses for exactly one cycle. out/ovf retain their values otherwise.
// CONFIGURATION
//  MAC_ACC_SATURATE_EN defined: the accumulator add saturates to
//    [-2^(bw_psum-1), 2^(bw_psum-1)-1]. A sticky group flag sets on any clamp, is cleared by first,
//    and is presented on ovf with out_valid.
//  Not defined: the add wraps modulo 2^bw_psum and ovf is tied to 0.
// STRUCTURE
//  - Package mac_pkg holds localparams and the widths: PROD_W = 2*bw, D = $clog2(pr),
//    TREE_W = 2*bw+D, plus the sign-extend function sext().
//  - Sub-module mac_tree_level: one registered adder-tree level, parametrised by input count and
//    width, enabled by valid.
//  - mac_acc_pipe instantiates D mac_tree_level levels via generate. It contains the product
//    stage, the accumulator stage and the tag shift chain.
// TESTING (defaults bw=8, pr=8, bw_psum=24)
//  1. All a=1, b=2, one beat first&last -> out=16 (0x000010), out_valid exactly 5 cycles later.
//  2. All a=-128, b=-128, 4-beat group with 2 idle gaps -> out=524288 (0x080000), single pulse.
//  3. All a=-3, b=5, first&last -> out=-120 (0xFFFF88); ovf=0.
//  4. Groups {1-beat sum 16} then {2-beat 8+8}, back-to-back -> out=16 then 16, no carry-over.
//  5. 64 beats of a=b=-128 (8388608 total) -> SATURATE_EN: out=0x7FFFFF, ovf=1;
//     else out=0x800000, ovf=0.
//  6. reset low for 1 cycle mid-group -> out_valid stays 0. A fresh group of 16 afterwards
//     -> out=16.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared widths and helpers for the pipelined multiply-accumulate datapath.
package mac_pkg;

    localparam int unsigned BW      = 8;
    localparam int unsigned PR      = 8;
    localparam int unsigned PROD_W  = 2 * BW;
    localparam int unsigned D       = $clog2(PR);
    localparam int unsigned TREE_W  = PROD_W + D;
    localparam int unsigned BW_PSUM = 2 * BW + 8;
    localparam int unsigned SEXT_W  = 64;

    // Sign-extend the low w bits of x to the full SEXT_W width.
    function automatic logic [SEXT_W-1:0] sext(input logic [SEXT_W-1:0] x,
                                               input int unsigned       w);
        logic signed [SEXT_W-1:0] t;
        t = $signed(x << (SEXT_W - w));
        return $unsigned(t >>> (SEXT_W - w));
    endfunction

endpackage

// File: rtl/mac_tree_level.sv
// One registered level of the signed adder tree: N inputs of W bits reduce to N/2 outputs
// of W+1 bits, captured only when the stage carries a valid beat.
module mac_tree_level
    import mac_pkg::*;
#(
    parameter int unsigned N = 2,
    parameter int unsigned W = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     en_i,
    input  logic [N*W-1:0]           d_i,
    output logic [(N/2)*(W+1)-1:0]   q_o
);

    localparam int unsigned NO = N / 2;
    localparam int unsigned WO = W + 1;

    logic [NO*WO-1:0] sum_d;
    logic [NO*WO-1:0] sum_q;

    // Pairwise sums with one bit of sign growth.
    always_comb begin
        sum_d = '0;
        for (int unsigned j = 0; j < NO; j++) begin
            sum_d[j*WO +: WO] = WO'(sext(SEXT_W'(d_i[(2*j)*W +: W]), W))
                              + WO'(sext(SEXT_W'(d_i[(2*j+1)*W +: W]), W));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sum_q <= '0;
        end else if (en_i) begin
            sum_q <= sum_d;
        end
    end

    assign q_o = sum_q;

endmodule

// File: rtl/mac_acc_pipe.sv
// Pipelined pr-lane signed MAC with registered adder tree and framed group accumulator.
// Optional feature: define MAC_ACC_SATURATE_EN for a saturating accumulator with sticky ovf.
module mac_acc_pipe
    import mac_pkg::*;
#(
    parameter int unsigned bw      = BW,
    parameter int unsigned pr      = PR,
    parameter int unsigned bw_psum = BW_PSUM
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic                 in_first,
    input  logic                 in_last,
    input  logic [pr*bw-1:0]     a,
    input  logic [pr*bw-1:0]     b,
    output logic [bw_psum-1:0]   out,
    output logic                 out_valid,
    output logic                 ovf
);

    localparam int unsigned PW = 2 * bw;
    localparam int unsigned NL = $clog2(pr);
    localparam int unsigned TW = PW + NL;

    logic [pr*PW-1:0]   prod_d;
    logic [pr*PW-1:0]   prod_q;
    logic [PW-1:0]      op_a;
    logic [PW-1:0]      op_b;
    logic [NL:0]        vld_q;
    logic [NL:0]        fst_q;
    logic [NL:0]        lst_q;
    logic [TW-1:0]      tree_sum;
    logic [bw_psum-1:0] sum_ext;
    logic [bw_psum-1:0] acc_d;
    logic [bw_psum-1:0] acc_q;
    logic               fin_q;
    logic [bw_psum-1:0] out_q;
    logic               out_valid_q;
    logic               ovf_q;

    // Lane products: operands widened to the product width before multiplying.
    always_comb begin
        prod_d = '0;
        op_a   = '0;
        op_b   = '0;
        for (int unsigned i = 0; i < pr; i++) begin
            op_a = PW'(sext(SEXT_W'(a[i*bw +: bw]), bw));
            op_b = PW'(sext(SEXT_W'(b[i*bw +: bw]), bw));
            prod_d[i*PW +: PW] = PW'(op_a * op_b);
        end
    end

    // Bit 0 of each tag chain belongs to the product stage, bit NL to the last tree level.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prod_q <= '0;
            vld_q  <= '0;
            fst_q  <= '0;
            lst_q  <= '0;
        end else begin
            if (in_valid) begin
                prod_q <= prod_d;
            end
            vld_q <= {vld_q[NL-1:0], in_valid};
            fst_q <= {fst_q[NL-1:0], in_valid & in_first};
            lst_q <= {lst_q[NL-1:0], in_valid & in_last};
        end
    end

    for (genvar k = 0; k < NL; k++) begin : g_lvl
        localparam int unsigned N = pr >> k;
        localparam int unsigned W = PW + k;

        logic [N*W-1:0]         d;
        logic [(N/2)*(W+1)-1:0] q;

        if (k == 0) begin : g_src_prod
            assign d = prod_q;
        end else begin : g_src_lvl
            assign d = g_lvl[k-1].q;
        end

        mac_tree_level #(
            .N (N),
            .W (W)
        ) u_level (
            .clk_i  (clk),
            .rst_ni (reset),
            .en_i   (vld_q[k]),
            .d_i    (d),
            .q_o    (q)
        );
    end

    assign tree_sum = g_lvl[NL-1].q;
    assign sum_ext  = bw_psum'(sext(SEXT_W'(tree_sum), TW));

`ifdef MAC_ACC_SATURATE_EN
    logic [bw_psum:0] acc_wide;
    logic             sat_d;
    logic             sat_q;

    // Saturating add; the sticky clamp flag restarts with every group opener.
    always_comb begin
        acc_d    = acc_q;
        sat_d    = sat_q;
        acc_wide = {acc_q[bw_psum-1], acc_q} + {sum_ext[bw_psum-1], sum_ext};
        if (vld_q[NL]) begin
            if (fst_q[NL]) begin
                acc_d = sum_ext;
                sat_d = 1'b0;
            end else if (acc_wide[bw_psum] != acc_wide[bw_psum-1]) begin
                acc_d = acc_wide[bw_psum] ? {1'b1, {(bw_psum-1){1'b0}}}
                                          : {1'b0, {(bw_psum-1){1'b1}}};
                sat_d = 1'b1;
            end else begin
                acc_d = acc_wide[bw_psum-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ovf_q <= 1'b0;
        end else if (fin_q) begin
            ovf_q <= sat_q;
        end
    end
`else
    // Wrapping add modulo 2^bw_psum.
    always_comb begin
        acc_d = acc_q;
        if (vld_q[NL]) begin
            acc_d = fst_q[NL] ? sum_ext : acc_q + sum_ext;
        end
    end

    always_ff @(posedge clk) begin
        ovf_q <= 1'b0;
    end
`endif

    // Accumulator and result stage; out holds between group completions.
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_q       <= '0;
            fin_q       <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            fin_q       <= vld_q[NL] & lst_q[NL];
            out_valid_q <= fin_q;
            if (fin_q) begin
                out_q <= acc_q;
            end
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign ovf       = ovf_q;

endmodule
